// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the unified-memory arbiter
package mem_arbiter_pkg;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_e;

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - BUSY-phase watchdog; expired_o once TIMEOUT cycles passed without ready
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data arbiter onto one unified memory port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEFAULT,
  parameter int DW           = DW_DEFAULT,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_req_i,
  input  logic [AW-1:0] i_addr_i,
  output logic [DW-1:0] i_rdata_o,
  output logic          i_ack_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ack_o,
  output logic          err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          stall_o
);

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

  arb_state_e    state_q, state_d;
  arb_port_e     owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          err_q, err_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          busy;
  logic          expired;

  assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

  // Held clear outside BUSY so every access starts counting from zero.
  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (!busy),
    .en_i     (busy && !mem_ready_i),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = err_q;
    streak_d  = streak_q;
    case (state_q)
      IDLE: begin
        // Data wins ties until it has starved a waiting fetch MAX_D_STREAK times.
        if (d_req_i && !(i_req_i && streak_q == SW'(MAX_D_STREAK))) begin
          state_d  = BUSY_D;
          owner_d  = PORT_D;
          we_d     = d_we_i;
          addr_d   = d_addr_i;
          wdata_d  = d_wdata_i;
          streak_d = i_req_i ? streak_q + SW'(1) : '0;
        end else if (i_req_i) begin
          state_d  = BUSY_I;
          owner_d  = PORT_I;
          we_d     = 1'b0;
          addr_d   = i_addr_i;
          streak_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready_i) begin
          state_d = RESP;
          err_d   = 1'b0;
          if (state_q == BUSY_I) begin
            i_rdata_d = mem_rdata_i;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end else if (expired) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= PORT_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
      streak_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
      streak_q  <= streak_d;
    end
  end

  assign mem_req_o   = busy;
  assign mem_we_o    = busy && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign i_ack_o     = (state_q == RESP) && (owner_q == PORT_I);
  assign d_ack_o     = (state_q == RESP) && (owner_q == PORT_D);
  assign err_o       = (state_q == RESP) && err_q;
  assign stall_o     = (i_req_i && !i_ack_o) || (d_req_i && !d_ack_o);

endmodule
